// File: rtl/serial_adder_if.sv
// serial_adder_if: operand/result bundle for the bit-serial adder.
//   master (requester) drives: start, a, b, cin, sub
//   slave  (adder)     drives: ready, done, sum, cout, ovf
// WIDTH must match the WIDTH of the serial_adder it connects to.
interface serial_adder_if #(
  parameter int WIDTH = 8
);
  logic             start;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             cin;
  logic             sub;
  logic             ready;
  logic             done;
  logic [WIDTH-1:0] sum;
  logic             cout;
  logic             ovf;

  modport master (
    output start, a, b, cin, sub,
    input  ready, done, sum, cout, ovf
  );

  modport slave (
    input  start, a, b, cin, sub,
    output ready, done, sum, cout, ovf
  );
endinterface

// File: rtl/serial_adder.sv
// serial_adder: bit-serial WIDTH-bit adder/subtractor, LSB first, one bit
// per clock through a single reused full-adder slice.
// Ports:
//   clk  - rising-edge clock
//   rst  - synchronous, active-high reset (priority over everything)
//   bus  - serial_adder_if.slave:
//          start/a/b/cin/sub in (sampled only on the accept edge),
//          ready (idle), done (one-cycle result pulse), sum/cout/ovf out.
// Timing: accept edge, WIDTH RUN cycles, one DONE cycle, back to IDLE.
// sub=1 computes A + ~B + 1; cout=1 then means no borrow.
module serial_adder #(
  parameter int WIDTH = 8
) (
  input  logic           clk,
  input  logic           rst,
  serial_adder_if.slave  bus
);

  generate
    if (WIDTH < 1) begin : g_bad_width
      $fatal(1, "serial_adder: WIDTH must be >= 1");
    end
  endgenerate

  localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_DONE
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [WIDTH-1:0] res_q, res_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             carry_q, carry_d;
  logic [WIDTH-1:0] sum_q, sum_d;
  logic             cout_q, cout_d;
  logic             ovf_q, ovf_d;

  // The single full-adder slice.
  logic s_bit;
  logic c_next;
  assign s_bit  = a_q[0] ^ b_q[0] ^ carry_q;
  assign c_next = (a_q[0] & b_q[0]) | (a_q[0] & carry_q) | (b_q[0] & carry_q);

  always_comb begin
    // NOTE: every signal gets its hold value first so no path through the
    // case below can leave one unassigned and infer a latch.
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    res_d   = res_q;
    cnt_d   = cnt_q;
    carry_d = carry_q;
    sum_d   = sum_q;
    cout_d  = cout_q;
    ovf_d   = ovf_q;

    case (state_q)
      S_IDLE: begin
        if (bus.start) begin
          a_d     = bus.a;
          // Subtraction is A + ~B + 1: invert B and seed the carry with 1.
          b_d     = bus.sub ? ~bus.b : bus.b;
          carry_d = bus.sub ? 1'b1 : bus.cin;
          cnt_d   = '0;
          state_d = S_RUN;
        end
      end

      S_RUN: begin
        a_d              = a_q >> 1;
        b_d              = b_q >> 1;
        res_d            = res_q >> 1;
        res_d[WIDTH-1]   = s_bit;
        carry_d          = c_next;
        cnt_d            = cnt_q + 1'b1;
        if (cnt_q == LAST_BIT) begin
          // Last bit: carry_q is the carry into the MSB, c_next the carry
          // out of it. Their XOR is signed overflow; for WIDTH=1 this is
          // simply cin XOR cout. Outputs load on the edge entering DONE.
          sum_d   = res_d;
          cout_d  = c_next;
          ovf_d   = carry_q ^ c_next;
          state_d = S_DONE;
        end
      end

      S_DONE: begin
        state_d = S_IDLE;
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    // NOTE: state updates use non-blocking assignments so every register
    // samples the pre-edge values regardless of statement order.
    if (rst) begin
      state_q <= S_IDLE;
      a_q     <= '0;
      b_q     <= '0;
      res_q   <= '0;
      cnt_q   <= '0;
      carry_q <= 1'b0;
      sum_q   <= '0;
      cout_q  <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      res_q   <= res_d;
      cnt_q   <= cnt_d;
      carry_q <= carry_d;
      sum_q   <= sum_d;
      cout_q  <= cout_d;
      ovf_q   <= ovf_d;
    end
  end

  assign bus.ready = (state_q == S_IDLE);
  assign bus.done  = (state_q == S_DONE);
  assign bus.sum   = sum_q;
  assign bus.cout  = cout_q;
  assign bus.ovf   = ovf_q;

endmodule

// File: tb/tb_serial_adder.sv
// Directed bench for serial_adder at WIDTH=8, WIDTH=1 and WIDTH=16
// (the last with a randomised sweep against an independent model).
module tb_serial_adder;

  logic clk;
  logic rst;
  int   n_tests;
  int   n_fail;
  int   cyc;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Per-unit stimulus/response views: 0 = WIDTH 8, 1 = WIDTH 1, 2 = WIDTH 16.
  logic        st [3];
  logic [15:0] av [3];
  logic [15:0] bv [3];
  logic        ci [3];
  logic        sb [3];
  logic [2:0]  rd, dn, co, ov;
  logic [15:0] sm0, sm1, sm2;

  serial_adder_if #(.WIDTH(8))  if8 ();
  serial_adder_if #(.WIDTH(1))  if1 ();
  serial_adder_if #(.WIDTH(16)) if16 ();

  assign if8.start  = st[0];
  assign if8.a      = av[0][7:0];
  assign if8.b      = bv[0][7:0];
  assign if8.cin    = ci[0];
  assign if8.sub    = sb[0];
  assign if1.start  = st[1];
  assign if1.a      = av[1][0];
  assign if1.b      = bv[1][0];
  assign if1.cin    = ci[1];
  assign if1.sub    = sb[1];
  assign if16.start = st[2];
  assign if16.a     = av[2];
  assign if16.b     = bv[2];
  assign if16.cin   = ci[2];
  assign if16.sub   = sb[2];

  assign rd  = {if16.ready, if1.ready, if8.ready};
  assign dn  = {if16.done,  if1.done,  if8.done};
  assign co  = {if16.cout,  if1.cout,  if8.cout};
  assign ov  = {if16.ovf,   if1.ovf,   if8.ovf};
  assign sm0 = {8'h00, if8.sum};
  assign sm1 = {15'h0, if1.sum};
  assign sm2 = if16.sum;

  serial_adder #(.WIDTH(8))  u_dut8  (.clk(clk), .rst(rst), .bus(if8));
  serial_adder #(.WIDTH(1))  u_dut1  (.clk(clk), .rst(rst), .bus(if1));
  serial_adder #(.WIDTH(16)) u_dut16 (.clk(clk), .rst(rst), .bus(if16));

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [15:0] sum_of(input int u);
    case (u)
      0:       return sm0;
      1:       return sm1;
      default: return sm2;
    endcase
  endfunction

  // One complete operation on unit u. Returns the result and the number of
  // clock edges from the accept edge (inclusive) to the first done cycle.
  task automatic run_op(input int u, input logic [15:0] a, input logic [15:0] b,
                        input logic c, input logic s,
                        output logic [15:0] r_sum, output logic r_cout,
                        output logic r_ovf, output int edges);
    int          k;
    logic [15:0] hold;
    logic        stable;
    k = 0;
    while (!rd[u] && k < 50) begin
      @(posedge clk); #1; k++;
    end
    check($sformatf("u%0d_ready_wait", u), rd[u], 1);
    av[u] = a; bv[u] = b; ci[u] = c; sb[u] = s; st[u] = 1'b1;
    @(posedge clk); #1;
    // Scramble inputs after accept; they must have no effect.
    st[u] = 1'b0; av[u] = ~a; bv[u] = ~b; ci[u] = ~c; sb[u] = ~s;
    hold   = sum_of(u);
    stable = 1'b1;
    k      = 0;
    while (!dn[u] && k < 60) begin
      @(posedge clk); #1; k++;
      if (!dn[u] && sum_of(u) != hold) stable = 1'b0;
    end
    check($sformatf("u%0d_done_seen", u), dn[u], 1);
    check($sformatf("u%0d_sum_hold", u), stable, 1);
    edges  = k + 1;
    r_sum  = sum_of(u);
    r_cout = co[u];
    r_ovf  = ov[u];
    @(posedge clk); #1;
    check($sformatf("u%0d_done_pulse", u), dn[u], 0);
    check($sformatf("u%0d_ready_back", u), rd[u], 1);
  endtask

  typedef struct {
    logic [7:0] a;
    logic [7:0] b;
    logic       cin;
    logic       sub;
    logic [7:0] s;
    logic       co;
    logic       ov;
  } vec8_t;

  vec8_t v8 [6] = '{
    '{8'hFF, 8'h01, 1'b0, 1'b0, 8'h00, 1'b1, 1'b0},
    '{8'h7F, 8'h01, 1'b0, 1'b0, 8'h80, 1'b0, 1'b1},
    '{8'h7F, 8'h00, 1'b1, 1'b0, 8'h80, 1'b0, 1'b1},
    '{8'h05, 8'h07, 1'b0, 1'b1, 8'hFE, 1'b0, 1'b0},
    '{8'h80, 8'h01, 1'b0, 1'b1, 8'h7F, 1'b1, 1'b1},
    '{8'h10, 8'h10, 1'b1, 1'b1, 8'h00, 1'b1, 1'b0}   // cin ignored in sub
  };

  logic [7:0] pa [3] = '{8'h11, 8'hA0, 8'h40};
  logic [7:0] pb [3] = '{8'h22, 8'h70, 8'h01};
  logic       ps [3] = '{1'b0, 1'b0, 1'b1};
  logic [7:0] pe [3] = '{8'h33, 8'h10, 8'h3F};

  initial begin
    logic [15:0] r_sum;
    logic        r_cout, r_ovf;
    int          edges, k, last_cyc, ndone;
    logic [15:0] ra, rb, bb, m_sum;
    logic        rc, rs, cc, m_co, m_ov;

    n_tests = 0; n_fail = 0; cyc = 0;
    for (int u = 0; u < 3; u++) begin
      st[u] = 1'b0; av[u] = '0; bv[u] = '0; ci[u] = 1'b0; sb[u] = 1'b0;
    end
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check("rst_ready8", rd[0], 1);
    check("rst_done8",  dn[0], 0);
    check("rst_sum8",   sm0,   0);
    check("rst_cout8",  co[0], 0);
    check("rst_ovf8",   ov[0], 0);
    check("rst_ready1", rd[1], 1);
    check("rst_ready16", rd[2], 1);
    rst = 1'b0;
    @(posedge clk); #1;

    // Directed WIDTH=8 vectors.
    for (int i = 0; i < 6; i++) begin
      run_op(0, {8'h00, v8[i].a}, {8'h00, v8[i].b}, v8[i].cin, v8[i].sub,
             r_sum, r_cout, r_ovf, edges);
      check($sformatf("v8_%0d_sum", i),  r_sum,  {8'h00, v8[i].s});
      check($sformatf("v8_%0d_cout", i), r_cout, v8[i].co);
      check($sformatf("v8_%0d_ovf", i),  r_ovf,  v8[i].ov);
      check($sformatf("v8_%0d_latency", i), edges, 9);
    end

    // start held high; operands scrambled during every RUN.
    st[0] = 1'b1; av[0] = {8'h00, pa[0]}; bv[0] = {8'h00, pb[0]}; ci[0] = 1'b0; sb[0] = ps[0];
    @(posedge clk); #1;
    check("pipe_busy0", rd[0], 0);
    av[0] = 16'h00FF; bv[0] = 16'h00FF; ci[0] = 1'b1; sb[0] = ~ps[0];
    last_cyc = 0;
    for (int op = 0; op < 3; op++) begin
      k = 0;
      while (!dn[0] && k < 40) begin
        @(posedge clk); #1; k++;
      end
      check($sformatf("pipe_done_%0d", op), dn[0], 1);
      check($sformatf("pipe_sum_%0d", op), sm0, {8'h00, pe[op]});
      if (op > 0) check($sformatf("pipe_period_%0d", op), cyc - last_cyc, 10);
      last_cyc = cyc;
      if (op < 2) begin
        av[0] = {8'h00, pa[op+1]}; bv[0] = {8'h00, pb[op+1]}; ci[0] = 1'b0; sb[0] = ps[op+1];
        @(posedge clk); #1;
        check($sformatf("pipe_ready_%0d", op), rd[0], 1);
        @(posedge clk); #1;
        check($sformatf("pipe_accept_%0d", op), rd[0], 0);
        av[0] = 16'h00FF; bv[0] = 16'h00FF; ci[0] = 1'b1; sb[0] = ~ps[op+1];
      end else begin
        st[0] = 1'b0;
      end
    end
    @(posedge clk); #1;
    check("pipe_cout_last", co[0], 1);

    // Reset during the 4th RUN cycle aborts the operation.
    st[0] = 1'b1; av[0] = 16'h0055; bv[0] = 16'h0011; ci[0] = 1'b0; sb[0] = 1'b0;
    @(posedge clk); #1;
    st[0] = 1'b0;
    repeat (3) begin
      @(posedge clk); #1;
    end
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    check("abort_ready", rd[0], 1);
    check("abort_done",  dn[0], 0);
    check("abort_sum",   sm0,   0);
    check("abort_cout",  co[0], 0);
    check("abort_ovf",   ov[0], 0);
    ndone = 0;
    repeat (12) begin
      @(posedge clk); #1;
      if (dn[0]) ndone++;
    end
    check("abort_no_done", ndone, 0);
    run_op(0, 16'h0012, 16'h0034, 1'b0, 1'b0, r_sum, r_cout, r_ovf, edges);
    check("after_abort_sum", r_sum, 16'h0046);

    // WIDTH=1 corner cases.
    run_op(1, 16'h1, 16'h1, 1'b1, 1'b0, r_sum, r_cout, r_ovf, edges);
    check("w1_a_sum", r_sum, 1); check("w1_a_cout", r_cout, 1);
    check("w1_a_ovf", r_ovf, 0); check("w1_a_latency", edges, 2);
    run_op(1, 16'h1, 16'h1, 1'b0, 1'b0, r_sum, r_cout, r_ovf, edges);
    check("w1_b_sum", r_sum, 0); check("w1_b_cout", r_cout, 1); check("w1_b_ovf", r_ovf, 1);
    run_op(1, 16'h0, 16'h1, 1'b0, 1'b1, r_sum, r_cout, r_ovf, edges);
    check("w1_c_sum", r_sum, 1); check("w1_c_cout", r_cout, 0); check("w1_c_ovf", r_ovf, 1);

    // WIDTH=16 random sweep against a reference model.
    for (int i = 0; i < 1000; i++) begin
      ra = 16'($urandom); rb = 16'($urandom);
      rc = 1'($urandom_range(0, 1)); rs = 1'($urandom_range(0, 1));
      bb = rs ? ~rb : rb;
      cc = rs ? 1'b1 : rc;
      {m_co, m_sum} = {1'b0, ra} + {1'b0, bb} + {16'h0, cc};
      m_ov = (ra[15] == bb[15]) && (m_sum[15] != ra[15]);
      run_op(2, ra, rb, rc, rs, r_sum, r_cout, r_ovf, edges);
      check($sformatf("w16_%0d_sum", i),  r_sum,  m_sum);
      check($sformatf("w16_%0d_cout", i), r_cout, m_co);
      check($sformatf("w16_%0d_ovf", i),  r_ovf,  m_ov);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
